// File: rtl/fetch_redirect_unit_pkg.sv
// ---------------------------------------------------------------------------
// pcpu_pkg
// Shared definitions for the fetch stage of the pipelined CPU:
//   - fsm_state_e      : fetch FSM states (BOOT / RUN / HALT)
//   - NOP_INSTR        : encoding used for IF/ID bubbles
//   - DEFAULT_RESET_PC : default PC loaded on reset
//   - align_word()     : clears the low two address bits of a target
// ---------------------------------------------------------------------------
package pcpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fsm_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Redirect targets are word aligned silently; misaligned low bits are
    // dropped rather than trapped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if_id.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_n_i        : clock, asynchronous active-low reset
//   hold_i                : keep current contents (highest priority)
//   flush_i               : replace contents with a NOP bubble (valid=0)
//   load_i                : capture instr_i / pc4_i as a valid instruction
//   instr_i, pc4_i        : fetched instruction and its PC+4
//   instr_o, pc4_o, valid_o : registered IF/ID contents
// With no control asserted the register keeps its contents.
// ---------------------------------------------------------------------------
module if_id_reg
    import pcpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q,   pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (hold_i) begin
            instr_d = instr_q;
        end else if (flush_i) begin
            // pc4 is left as-is; only the instruction and valid define a bubble
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
// Instruction-fetch stage: PC register, next-PC selection, fetch FSM,
// saturating redirect counter, and the IF/ID register (if_id_reg).
// Ports:
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   stall_i                 : load-use hold from the hazard unit
//   branch_en_i / _target_i : taken branch resolved in ID and its target
//   jump_i / jump_target_i  : j/jal/jr decoded in ID and its target
//   halt_i                  : halt request decoded in ID
//   imem_instr_i            : combinational imem read data at imem_addr_o
//   imem_addr_o             : current PC
//   if_id_pc4_o/_instr_o/_valid_o : IF/ID contents
//   halted_o                : FSM is in HALT
//   redirect_cnt_o          : taken redirect count, saturating
// ---------------------------------------------------------------------------
module fetch_redirect_unit
    import pcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_i,
    input  logic             branch_en_i,
    input  logic [31:0]      branch_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    input  logic             halt_i,
    input  logic [31:0]      imem_instr_i,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    fsm_state_e       state_q;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pc_plus4;
    logic             ifid_hold, ifid_flush, ifid_load;

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc_q + 32'd4;

    // IF/ID controls follow the same priority as the PC update below.
    always_comb begin
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        ifid_load  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (stall_i)                              ifid_hold  = 1'b1;
                else if (halt_i || branch_en_i || jump_i) ifid_flush = 1'b1;
                else                                      ifid_load  = 1'b1;
            end
            default: ifid_flush = 1'b1;  // BOOT and HALT keep a bubble
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (stall_i) begin
                        // ID re-evaluates its controls once the stall clears
                        state_q <= ST_RUN;
                    end else if (halt_i) begin
                        state_q <= ST_HALT;
                    end else if (branch_en_i || jump_i) begin
                        // branch outranks jump when both are asserted
                        pc_q <= branch_en_i ? align_word(branch_target_i)
                                            : align_word(jump_target_i);
                        if (cnt_q != {CNT_W{1'b1}})
                            cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        pc_q <= pc_plus4;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_BOOT;
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .hold_i  (ifid_hold),
        .flush_i (ifid_flush),
        .load_i  (ifid_load),
        .instr_i (imem_instr_i),
        .pc4_i   (pc_plus4),
        .instr_o (if_id_instr_o),
        .pc4_o   (if_id_pc4_o),
        .valid_o (if_id_valid_o)
    );

    assign imem_addr_o    = pc_q;
    assign halted_o       = (state_q == ST_HALT);
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_unit
// Directed bench for fetch_redirect_unit (CNT_W=4 so saturation is reachable).
// ---------------------------------------------------------------------------
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branch_en, jump, halt;
    logic [31:0] branch_target, jump_target, imem_instr;
    logic [31:0] imem_addr, if_id_pc4, if_id_instr;
    logic        if_id_valid, halted;
    logic [3:0]  redirect_cnt;

    int vectors    = 0;
    int miscompares = 0;

    fetch_redirect_unit #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (4)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .stall_i         (stall),
        .branch_en_i     (branch_en),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_target_i   (jump_target),
        .halt_i          (halt),
        .imem_instr_i    (imem_instr),
        .imem_addr_o     (imem_addr),
        .if_id_pc4_o     (if_id_pc4),
        .if_id_instr_o   (if_id_instr),
        .if_id_valid_o   (if_id_valid),
        .halted_o        (halted),
        .redirect_cnt_o  (redirect_cnt)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; branch_en = 0; jump = 0; halt = 0;
        branch_target = 32'h0; jump_target = 32'h0;
    endtask

    // Leaves the DUT just past the BOOT cycle, in RUN with PC=32'h3000.
    task automatic reset_and_boot();
        clear_inputs();
        rst_n = 0;
        repeat (2) step();
        rst_n = 1;
        step();
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_instr = 32'h2008_0005;
        rst_n = 0;
        repeat (2) step();
        vectors++;
        if (imem_addr !== 32'h3000 || if_id_instr !== 32'h0 || if_id_pc4 !== 32'h0 ||
            if_id_valid !== 1'b0 || redirect_cnt !== 4'h0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: addr=%h instr=%h pc4=%h valid=%b cnt=%h halted=%b required addr=00003000 rest zero",
                     imem_addr, if_id_instr, if_id_pc4, if_id_valid, redirect_cnt, halted);
        end
        rst_n = 1;
        step();
        vectors++;
        if (imem_addr !== 32'h3000 || if_id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL boot_cycle: addr=%h valid=%b required 00003000/0", imem_addr, if_id_valid);
        end
        step();
        vectors++;
        if (if_id_instr !== 32'h2008_0005 || if_id_pc4 !== 32'h3004 ||
            imem_addr !== 32'h3004 || if_id_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL first_fetch: instr=%h pc4=%h addr=%h valid=%b required 20080005/00003004/00003004/1",
                     if_id_instr, if_id_pc4, imem_addr, if_id_valid);
        end
    endtask

    task automatic test_branch();
        reset_and_boot();
        imem_instr = 32'h0123_4567;
        repeat (4) step();
        vectors++;
        if (imem_addr !== 32'h3010) begin
            miscompares++;
            $display("FAIL seq_fetch_pc: addr=%h required 00003010", imem_addr);
        end
        branch_en = 1; branch_target = 32'h3040;
        step();
        branch_en = 0;
        vectors++;
        if (imem_addr !== 32'h3040 || if_id_valid !== 1'b0 || redirect_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL branch_redirect: addr=%h valid=%b cnt=%0d required 00003040/0/1",
                     imem_addr, if_id_valid, redirect_cnt);
        end
        step();
        vectors++;
        if (if_id_pc4 !== 32'h3044 || if_id_valid !== 1'b1 || imem_addr !== 32'h3044 ||
            if_id_instr !== 32'h0123_4567) begin
            miscompares++;
            $display("FAIL branch_target_fetch: pc4=%h valid=%b addr=%h instr=%h required 00003044/1/00003044/01234567",
                     if_id_pc4, if_id_valid, imem_addr, if_id_instr);
        end
    endtask

    task automatic test_stall();
        reset_and_boot();
        imem_instr = 32'hAAAA_5555;
        step();  // PC=3004, IF/ID holds AAAA5555 / 3004
        imem_instr = 32'h1111_2222;
        stall = 1; branch_en = 1; branch_target = 32'h3100;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (imem_addr !== 32'h3004 || if_id_pc4 !== 32'h3004 || if_id_instr !== 32'hAAAA_5555 ||
                if_id_valid !== 1'b1 || redirect_cnt !== 4'd0) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: addr=%h pc4=%h instr=%h valid=%b cnt=%0d required 00003004/00003004/aaaa5555/1/0",
                         i, imem_addr, if_id_pc4, if_id_instr, if_id_valid, redirect_cnt);
            end
        end
        stall = 0;
        step();
        branch_en = 0;
        vectors++;
        if (imem_addr !== 32'h3100 || if_id_valid !== 1'b0 || redirect_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL stall_release_branch: addr=%h valid=%b cnt=%0d required 00003100/0/1",
                     imem_addr, if_id_valid, redirect_cnt);
        end
    endtask

    task automatic test_priority();
        reset_and_boot();
        branch_en = 1; branch_target = 32'h3203;
        jump = 1;      jump_target   = 32'h4000;
        step();
        branch_en = 0; jump = 0;
        vectors++;
        if (imem_addr !== 32'h3200 || redirect_cnt !== 4'd1 || if_id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL branch_over_jump: addr=%h cnt=%0d valid=%b required 00003200/1/0",
                     imem_addr, redirect_cnt, if_id_valid);
        end
        jump = 1; jump_target = 32'h4003;
        step();
        jump = 0;
        vectors++;
        if (imem_addr !== 32'h4000 || redirect_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL jump_align: addr=%h cnt=%0d required 00004000/2", imem_addr, redirect_cnt);
        end
    endtask

    task automatic test_halt();
        reset_and_boot();
        step();  // PC=3004
        halt = 1; branch_en = 1; branch_target = 32'h3500;
        step();
        halt = 0;
        vectors++;
        if (halted !== 1'b1 || imem_addr !== 32'h3004 || if_id_valid !== 1'b0 ||
            if_id_instr !== 32'h0 || redirect_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL halt_accept: halted=%b addr=%h valid=%b instr=%h cnt=%0d required 1/00003004/0/00000000/0",
                     halted, imem_addr, if_id_valid, if_id_instr, redirect_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            stall = i[0]; branch_en = ~i[0]; jump = 1; jump_target = 32'h7000;
            step();
            vectors++;
            if (halted !== 1'b1 || imem_addr !== 32'h3004 || if_id_valid !== 1'b0 ||
                redirect_cnt !== 4'd0) begin
                miscompares++;
                $display("FAIL halt_frozen[%0d]: halted=%b addr=%h valid=%b cnt=%0d required 1/00003004/0/0",
                         i, halted, imem_addr, if_id_valid, redirect_cnt);
            end
        end
        clear_inputs();
        #2 rst_n = 0;
        #1;
        vectors++;
        if (imem_addr !== 32'h3000 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_in_halt: addr=%h halted=%b required 00003000/0", imem_addr, halted);
        end
        step();
        rst_n = 1;
    endtask

    task automatic test_saturation_wrap();
        reset_and_boot();
        imem_instr = 32'hCAFE_0001;
        jump = 1; jump_target = 32'h5000;
        repeat (15) step();
        vectors++;
        if (redirect_cnt !== 4'hF) begin
            miscompares++;
            $display("FAIL cnt_reach_max: cnt=%h required f", redirect_cnt);
        end
        repeat (5) step();
        vectors++;
        if (redirect_cnt !== 4'hF) begin
            miscompares++;
            $display("FAIL cnt_saturate: cnt=%h required f", redirect_cnt);
        end
        jump_target = 32'hFFFF_FFFC;
        step();
        jump = 0;
        vectors++;
        if (imem_addr !== 32'hFFFF_FFFC || redirect_cnt !== 4'hF) begin
            miscompares++;
            $display("FAIL jump_top: addr=%h cnt=%h required fffffffc/f", imem_addr, redirect_cnt);
        end
        step();
        vectors++;
        if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1 ||
            if_id_instr !== 32'hCAFE_0001) begin
            miscompares++;
            $display("FAIL pc_wrap: addr=%h pc4=%h valid=%b instr=%h required 00000000/00000000/1/cafe0001",
                     imem_addr, if_id_pc4, if_id_valid, if_id_instr);
        end
    endtask

    initial begin
        clear_inputs();
        imem_instr = 32'h0;
        rst_n = 0;
        test_reset();
        test_branch();
        test_stall();
        test_priority();
        test_halt();
        test_saturation_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded bound, required completion");
        $fatal(1);
    end

endmodule
